// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//
// Bundles the pipeline-side signals exchanged with the hazard controller.
//   master : pipeline view. Drives the decode/execute/memory hazard sources
//            and receives the stall/flush enables and status.
//   slave  : hazard controller view. The mirror of master.
//
// Signals
//   instrRs_D, instrRt_D  [4:0]  source registers of the instruction in D
//   useRs_D, useRt_D             D really reads Rs / Rt
//   branch_D                     D holds a branch comparing registers in D
//   branchTaken_D                branch/jump in D resolved taken
//   mdUse_D                      D holds mfhi/mflo/mthi/mtlo
//   writeReg_E [4:0], regWrite_E, memRead_E   destination of E
//   mdStart_E, mdDiv_E           mult/div start in E (mdDiv_E=1 -> divide)
//   writeReg_M [4:0], memRead_M  load in M
//   memReq_M, memReady_M         data-memory access / completion
//   stall_F/D/E/M                hold PC / pipeline register of that stage
//   flush_D/E/M/WB               load a bubble into that stage's register
//   mdBusy                       mult/div unit occupied
//   memErr                       sticky memory-timeout flag
//   stallCount [15:0]            saturating count of stall_F cycles
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic [4:0]  instrRs_D;
    logic [4:0]  instrRt_D;
    logic        useRs_D;
    logic        useRt_D;
    logic        branch_D;
    logic        branchTaken_D;
    logic        mdUse_D;
    logic [4:0]  writeReg_E;
    logic        regWrite_E;
    logic        memRead_E;
    logic        mdStart_E;
    logic        mdDiv_E;
    logic [4:0]  writeReg_M;
    logic        memRead_M;
    logic        memReq_M;
    logic        memReady_M;

    logic        stall_F;
    logic        stall_D;
    logic        stall_E;
    logic        stall_M;
    logic        flush_D;
    logic        flush_E;
    logic        flush_M;
    logic        flush_WB;
    logic        mdBusy;
    logic        memErr;
    logic [15:0] stallCount;

    modport master (
        output instrRs_D, instrRt_D, useRs_D, useRt_D, branch_D, branchTaken_D,
               mdUse_D, writeReg_E, regWrite_E, memRead_E, mdStart_E, mdDiv_E,
               writeReg_M, memRead_M, memReq_M, memReady_M,
        input  stall_F, stall_D, stall_E, stall_M,
               flush_D, flush_E, flush_M, flush_WB,
               mdBusy, memErr, stallCount
    );

    modport slave (
        input  instrRs_D, instrRt_D, useRs_D, useRt_D, branch_D, branchTaken_D,
               mdUse_D, writeReg_E, regWrite_E, memRead_E, mdStart_E, mdDiv_E,
               writeReg_M, memRead_M, memReq_M, memReady_M,
        output stall_F, stall_D, stall_E, stall_M,
               flush_D, flush_E, flush_M, flush_WB,
               mdBusy, memErr, stallCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the 5-stage MIPS core. Covers the hazards the
// forwarding unit cannot resolve: load-use, branch compare in D, mult/div
// structural and HI/LO-use hazards, and data-memory wait states. Produces the
// per-stage stall and flush enables, tracks mult/div occupancy, memory wait
// time (with a sticky timeout flag) and a saturating stall-cycle count.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   hz     hazard_ctrl_if.slave (hazard sources in, stall/flush/status out)
//
// Parameters
//   MUL_LAT      cycles the mult/div unit is busy after a multiply (1..63)
//   DIV_LAT      cycles busy after a divide (1..63)
//   MEM_TIMEOUT  MEM_WAIT cycles before memErr sets (1..255)
//
// Stall/flush outputs are combinational so they act in the hazard cycle.
// While rst_n is low every stage is flushed and nothing is stalled.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MUL_LAT     = 4,
    parameter int DIV_LAT     = 12,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    localparam logic [5:0] MUL_LAT_C     = 6'(MUL_LAT);
    localparam logic [5:0] DIV_LAT_C     = 6'(DIV_LAT);
    localparam logic [7:0] MEM_TIMEOUT_C = 8'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    // True when the D instruction reads register r; r0 never creates a hazard.
    function automatic logic src_match(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return (r != 5'd0) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
    endfunction

    // Registered state
    state_t      state_q,       state_d;
    logic [5:0]  md_cnt_q,      md_cnt_d;
    logic        md_busy_q,     md_busy_d;
    logic [7:0]  wait_cnt_q,    wait_cnt_d;
    logic        mem_err_q,     mem_err_d;
    logic [15:0] stall_cnt_q,   stall_cnt_d;

    // Hazard terms
    logic        freeze_s;
    logic        md_haz_s;
    logic        use_haz_s;
    logic        md_accept_s;
    logic        match_e_s;
    logic        match_m_s;

    // Stall/flush pattern
    logic        stall_f_s;
    logic        stall_d_s;
    logic        stall_e_s;
    logic        stall_m_s;
    logic        flush_d_s;
    logic        flush_e_s;
    logic        flush_m_s;
    logic        flush_wb_s;

    // Hazard condition decode from current inputs and registered occupancy.
    always_comb begin
        match_e_s = src_match(hz.writeReg_E, hz.instrRs_D, hz.instrRt_D,
                              hz.useRs_D, hz.useRt_D);
        match_m_s = src_match(hz.writeReg_M, hz.instrRs_D, hz.instrRt_D,
                              hz.useRs_D, hz.useRt_D);

        freeze_s  = hz.memReq_M & ~hz.memReady_M;
        md_haz_s  = hz.mdStart_E & md_busy_q;

        // mfhi/mflo must also wait on a mult/div that is only now starting in E.
        use_haz_s = (hz.memRead_E & hz.regWrite_E & match_e_s)
                  | (hz.branch_D  & hz.regWrite_E & match_e_s)
                  | (hz.branch_D  & hz.memRead_M  & match_m_s)
                  | (hz.mdUse_D   & (md_busy_q | hz.mdStart_E));

        // A start that collides with a freeze is not taken; E holds it and it
        // retries on the first unfrozen cycle.
        md_accept_s = hz.mdStart_E & ~md_busy_q & ~freeze_s;
    end

    // Priority stall/flush selection; reset forces the all-flush pattern.
    always_comb begin
        stall_f_s  = 1'b0;
        stall_d_s  = 1'b0;
        stall_e_s  = 1'b0;
        stall_m_s  = 1'b0;
        flush_d_s  = 1'b0;
        flush_e_s  = 1'b0;
        flush_m_s  = 1'b0;
        flush_wb_s = 1'b0;
        if (!rst_n) begin
            flush_d_s  = 1'b1;
            flush_e_s  = 1'b1;
            flush_m_s  = 1'b1;
            flush_wb_s = 1'b1;
        end else if (freeze_s) begin
            // Whole pipe holds; WB gets a bubble so the stalled M result is
            // not written back twice.
            stall_f_s  = 1'b1;
            stall_d_s  = 1'b1;
            stall_e_s  = 1'b1;
            stall_m_s  = 1'b1;
            flush_wb_s = 1'b1;
        end else if (md_haz_s) begin
            stall_f_s  = 1'b1;
            stall_d_s  = 1'b1;
            stall_e_s  = 1'b1;
            flush_m_s  = 1'b1;
        end else if (use_haz_s) begin
            stall_f_s  = 1'b1;
            stall_d_s  = 1'b1;
            flush_e_s  = 1'b1;
            flush_d_s  = hz.branchTaken_D & ~stall_d_s;
        end else begin
            flush_d_s  = hz.branchTaken_D;
        end
    end

    // Mult/div occupancy: load latency on accept, otherwise count down.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_accept_s) begin
            md_cnt_d = hz.mdDiv_E ? DIV_LAT_C : MUL_LAT_C;
        end else if (md_cnt_q != 6'd0) begin
            md_cnt_d = md_cnt_q - 6'd1;
        end else begin
            md_cnt_d = md_cnt_q;
        end
        md_busy_d = (md_cnt_d != 6'd0);
    end

    // Memory-wait FSM next state, wait counter and sticky timeout flag.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = 8'd0;
                if (freeze_s) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
                if (hz.memReady_M || !hz.memReq_M) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_MEM_WAIT;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase

        // Only a MEM_WAIT cycle can advance the counter onto the threshold.
        if ((state_q == ST_MEM_WAIT) && (wait_cnt_d == MEM_TIMEOUT_C)) begin
            mem_err_d = 1'b1;
        end else begin
            mem_err_d = mem_err_q;
        end
    end

    // Saturating count of cycles in which fetch is held.
    always_comb begin
        if (stall_f_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with asynchronous reset; reset aborts any mult/div or wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            md_cnt_q    <= 6'd0;
            md_busy_q   <= 1'b0;
            wait_cnt_q  <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            md_busy_q   <= md_busy_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_F    = stall_f_s;
    assign hz.stall_D    = stall_d_s;
    assign hz.stall_E    = stall_e_s;
    assign hz.stall_M    = stall_m_s;
    assign hz.flush_D    = flush_d_s;
    assign hz.flush_E    = flush_e_s;
    assign hz.flush_M    = flush_m_s;
    assign hz.flush_WB   = flush_wb_s;
    assign hz.mdBusy     = md_busy_q;
    assign hz.memErr     = mem_err_q;
    assign hz.stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. A table of single-cycle vectors covers the
// combinational stall/flush decode from idle state; hand-written sequences
// cover the multi-cycle behaviour (load-use, branch-on-load, divide + mfhi,
// back-to-back mult, freeze vs. start, memory wait/timeout, reset mid-divide).
// Pattern encoding: {stall_F, stall_D, stall_E, stall_M,
//                    flush_D, flush_E, flush_M, flush_WB}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    hazard_ctrl_if hif ();

    hazard_ctrl #(
        .MUL_LAT     (4),
        .DIV_LAT     (12),
        .MEM_TIMEOUT (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       br;
        logic       br_tk;
        logic       md_use;
        logic [4:0] wr_e;
        logic       rw_e;
        logic       mr_e;
        logic [4:0] wr_m;
        logic       mr_m;
        logic       mreq;
        logic       mrdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [16];

    localparam logic [7:0] P_IDLE   = 8'b0000_0000;
    localparam logic [7:0] P_USE    = 8'b1100_0100;
    localparam logic [7:0] P_MD     = 8'b1110_0010;
    localparam logic [7:0] P_FREEZE = 8'b1111_0001;
    localparam logic [7:0] P_TAKEN  = 8'b0000_1000;
    localparam logic [7:0] P_RESET  = 8'b0000_1111;

    function automatic vec_t mk(
        input string n, input logic [4:0] rs, input logic [4:0] rt,
        input logic urs, input logic urt, input logic br, input logic brt,
        input logic mdu, input logic [4:0] wre, input logic rwe, input logic mre,
        input logic [4:0] wrm, input logic mrm, input logic mq, input logic mr,
        input logic [7:0] e
    );
        vec_t v;
        v.name = n;   v.rs = rs;     v.rt = rt;     v.use_rs = urs; v.use_rt = urt;
        v.br = br;    v.br_tk = brt; v.md_use = mdu;
        v.wr_e = wre; v.rw_e = rwe;  v.mr_e = mre;
        v.wr_m = wrm; v.mr_m = mrm;  v.mreq = mq;   v.mrdy = mr;
        v.exp = e;
        return v;
    endfunction

    task automatic set_idle();
        hif.instrRs_D = 5'd0;  hif.instrRt_D = 5'd0;
        hif.useRs_D = 1'b0;    hif.useRt_D = 1'b0;
        hif.branch_D = 1'b0;   hif.branchTaken_D = 1'b0; hif.mdUse_D = 1'b0;
        hif.writeReg_E = 5'd0; hif.regWrite_E = 1'b0;    hif.memRead_E = 1'b0;
        hif.mdStart_E = 1'b0;  hif.mdDiv_E = 1'b0;
        hif.writeReg_M = 5'd0; hif.memRead_M = 1'b0;
        hif.memReq_M = 1'b0;   hif.memReady_M = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        hif.instrRs_D = v.rs;     hif.instrRt_D = v.rt;
        hif.useRs_D = v.use_rs;   hif.useRt_D = v.use_rt;
        hif.branch_D = v.br;      hif.branchTaken_D = v.br_tk; hif.mdUse_D = v.md_use;
        hif.writeReg_E = v.wr_e;  hif.regWrite_E = v.rw_e;     hif.memRead_E = v.mr_e;
        hif.mdStart_E = 1'b0;     hif.mdDiv_E = 1'b0;
        hif.writeReg_M = v.wr_m;  hif.memRead_M = v.mr_m;
        hif.memReq_M = v.mreq;    hif.memReady_M = v.mrdy;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pat(input string nm, input logic [7:0] exp);
        logic [7:0] act;
        act = {hif.stall_F, hif.stall_D, hif.stall_E, hif.stall_M,
               hif.flush_D, hif.flush_E, hif.flush_M, hif.flush_WB};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Pulse reset for two edges; returns just after an edge with rst_n high.
    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_stalls;
        int busy_n;
        int stall_n;
        int mism;

        clk = 1'b0;
        rst_n = 1'b1;
        n_checks = 0;
        n_errors = 0;
        set_idle();

        vecs[0]  = mk("idle",           5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, P_IDLE);
        vecs[1]  = mk("load_use_rs",    5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, P_USE);
        vecs[2]  = mk("load_rs_unused", 5'd9,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, P_IDLE);
        vecs[3]  = mk("load_use_rt",    5'd0,  5'd7,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, P_USE);
        vecs[4]  = mk("load_r0",        5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, P_IDLE);
        vecs[5]  = mk("alu_e_nobranch", 5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, P_IDLE);
        vecs[6]  = mk("branch_alu_e",   5'd0,  5'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, P_USE);
        vecs[7]  = mk("branch_load_m",  5'd0,  5'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, P_USE);
        vecs[8]  = mk("load_m_nobr",    5'd0,  5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, P_IDLE);
        vecs[9]  = mk("taken",          5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, P_TAKEN);
        vecs[10] = mk("taken_loaduse",  5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, P_USE);
        vecs[11] = mk("freeze",         5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, P_FREEZE);
        vecs[12] = mk("freeze_prio",    5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, P_FREEZE);
        vecs[13] = mk("mem_ready",      5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, P_IDLE);
        vecs[14] = mk("mfhi_idle",      5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, P_IDLE);
        vecs[15] = mk("branch_nomatch", 5'd0,  5'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, P_IDLE);

        // Reset state while rst_n is held low.
        #1;
        rst_n = 1'b0;
        #1;
        chk_pat("reset_pattern", P_RESET);
        chk_val("reset_mdBusy", 32'(hif.mdBusy), 32'd0);
        chk_val("reset_memErr", 32'(hif.memErr), 32'd0);
        chk_val("reset_stallCount", 32'(hif.stallCount), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table of single-cycle vectors from idle state.
        exp_stalls = 0;
        for (int i = 0; i < 16; i++) begin
            apply_vec(vecs[i]);
            #1;
            chk_pat(vecs[i].name, vecs[i].exp);
            if (vecs[i].exp[7]) exp_stalls++;
            tick();
        end
        set_idle();
        #1;
        chk_val("table_stallCount", 32'(hif.stallCount), 32'(exp_stalls));
        chk_val("table_mdBusy", 32'(hif.mdBusy), 32'd0);

        // Load-use: one stall, then the load is in M and forwarding covers it.
        do_reset();
        hif.instrRs_D = 5'd9; hif.useRs_D = 1'b1;
        hif.writeReg_E = 5'd9; hif.regWrite_E = 1'b1; hif.memRead_E = 1'b1;
        #1;
        chk_pat("lu_cycle1", P_USE);
        tick();
        hif.writeReg_E = 5'd0; hif.regWrite_E = 1'b0; hif.memRead_E = 1'b0;
        hif.writeReg_M = 5'd9; hif.memRead_M = 1'b1;
        #1;
        chk_pat("lu_cycle2", P_IDLE);
        tick();
        set_idle();
        #1;
        chk_val("lu_stallCount", 32'(hif.stallCount), 32'd1);

        // Branch on load: two stalls; with r0 none.
        for (int pass = 0; pass < 2; pass++) begin
            logic [4:0] r;
            r = (pass == 0) ? 5'd11 : 5'd0;
            do_reset();
            hif.branch_D = 1'b1; hif.instrRt_D = r; hif.useRt_D = 1'b1;
            hif.writeReg_E = r; hif.regWrite_E = 1'b1; hif.memRead_E = 1'b1;
            #1;
            chk_pat(pass == 0 ? "bl_cycle1" : "bl0_cycle1", pass == 0 ? P_USE : P_IDLE);
            tick();
            hif.writeReg_E = 5'd0; hif.regWrite_E = 1'b0; hif.memRead_E = 1'b0;
            hif.writeReg_M = r; hif.memRead_M = 1'b1;
            #1;
            chk_pat(pass == 0 ? "bl_cycle2" : "bl0_cycle2", pass == 0 ? P_USE : P_IDLE);
            tick();
            hif.writeReg_M = 5'd0; hif.memRead_M = 1'b0;
            #1;
            chk_pat(pass == 0 ? "bl_cycle3" : "bl0_cycle3", P_IDLE);
            tick();
            set_idle();
            #1;
            chk_val(pass == 0 ? "bl_stallCount" : "bl0_stallCount",
                    32'(hif.stallCount), pass == 0 ? 32'd2 : 32'd0);
        end

        // Divide followed by mfhi held in D.
        do_reset();
        hif.mdStart_E = 1'b1; hif.mdDiv_E = 1'b1; hif.mdUse_D = 1'b1;
        #1;
        chk_pat("div_start", P_USE);
        chk_val("div_start_busy", 32'(hif.mdBusy), 32'd0);
        tick();
        hif.mdStart_E = 1'b0; hif.mdDiv_E = 1'b0;
        busy_n = 0; stall_n = 0; mism = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (hif.mdBusy === 1'b1) busy_n++;
            if (hif.stall_D === 1'b1) stall_n++;
            if (hif.stall_D !== hif.mdBusy) mism++;
            tick();
        end
        chk_val("div_busy_cycles", 32'(busy_n), 32'd12);
        chk_val("div_total_stalls", 32'(stall_n + 1), 32'd13);
        chk_val("div_release_align", 32'(mism), 32'd0);
        chk_val("div_stallCount", 32'(hif.stallCount), 32'd13);

        // Back-to-back multiply: second start waits out the first.
        do_reset();
        hif.mdStart_E = 1'b1;
        #1;
        chk_pat("mul1_accept", P_IDLE);
        tick();
        mism = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            if ({hif.stall_F, hif.stall_D, hif.stall_E, hif.stall_M, hif.flush_D,
                 hif.flush_E, hif.flush_M, hif.flush_WB} !== P_MD) mism++;
            if (hif.mdBusy !== 1'b1) mism++;
            tick();
        end
        chk_val("mul2_hazard_cycles", 32'(mism), 32'd0);
        #1;
        chk_pat("mul2_accept", P_IDLE);
        chk_val("mul2_accept_busy", 32'(hif.mdBusy), 32'd0);
        tick();
        hif.mdStart_E = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (hif.mdBusy === 1'b1) busy_n++;
            tick();
        end
        chk_val("mul2_busy_cycles", 32'(busy_n), 32'd4);
        chk_val("mul_stallCount", 32'(hif.stallCount), 32'd4);

        // Start during freeze is not accepted; retried when unfrozen.
        do_reset();
        hif.mdStart_E = 1'b1; hif.memReq_M = 1'b1;
        #1;
        chk_pat("frz_start", P_FREEZE);
        tick();
        hif.memReq_M = 1'b0;
        #1;
        chk_val("frz_no_accept", 32'(hif.mdBusy), 32'd0);
        chk_pat("frz_retry", P_IDLE);
        tick();
        hif.mdStart_E = 1'b0;
        #1;
        chk_val("frz_retry_busy", 32'(hif.mdBusy), 32'd1);

        // Memory wait of three cycles, then ready.
        do_reset();
        hif.memReq_M = 1'b1;
        mism = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if ({hif.stall_F, hif.stall_D, hif.stall_E, hif.stall_M, hif.flush_D,
                 hif.flush_E, hif.flush_M, hif.flush_WB} !== P_FREEZE) mism++;
            tick();
        end
        chk_val("mw_freeze_cycles", 32'(mism), 32'd0);
        hif.memReady_M = 1'b1;
        #1;
        chk_pat("mw_ready", P_IDLE);
        tick();
        set_idle();
        #1;
        chk_val("mw_memErr", 32'(hif.memErr), 32'd0);
        chk_val("mw_stallCount", 32'(hif.stallCount), 32'd3);

        // Long wait sets the sticky timeout flag; freeze itself continues.
        hif.memReq_M = 1'b1;
        for (int i = 0; i < 70; i++) begin
            #1;
            if (i == 60) chk_val("to_early", 32'(hif.memErr), 32'd0);
            tick();
        end
        #1;
        chk_val("to_memErr", 32'(hif.memErr), 32'd1);
        chk_pat("to_still_frozen", P_FREEZE);
        tick();
        set_idle();
        tick();
        tick();
        chk_val("to_sticky", 32'(hif.memErr), 32'd1);

        // Reset mid-divide aborts everything.
        hif.mdStart_E = 1'b1; hif.mdDiv_E = 1'b1; hif.mdUse_D = 1'b1;
        tick();
        hif.mdStart_E = 1'b0; hif.mdDiv_E = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_pat("rst_mid_pattern", P_RESET);
        chk_val("rst_mid_busy", 32'(hif.mdBusy), 32'd0);
        chk_val("rst_mid_stallCount", 32'(hif.stallCount), 32'd0);
        chk_val("rst_mid_memErr", 32'(hif.memErr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk_pat("rst_release_idle", P_IDLE);
        chk_val("rst_release_busy", 32'(hif.mdBusy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the forwarding unit and covers every hazard that forwarding cannot resolve: load-use, branch-compare-in-D, multiply/divide structural and HI/LO-use hazards, and data-memory wait states. It drives per-stage stall and flush enables to the pipeline registers. It also tracks multiply/divide occupancy, memory wait time and a stall-cycle performance count.

## Interface
Parameters:
- MUL_LAT, 4, cycles the mult/div unit is busy after a multiply starts (1..63)
- DIV_LAT, 12, cycles busy after a divide starts (1..63)
- MEM_TIMEOUT, 64, consecutive frozen cycles before memErr sets (1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instrRs_D, instrRt_D  in  5  source registers of the instruction in D
- useRs_D, useRt_D  in  1  the D instruction actually reads Rs / Rt
- branch_D  in  1  D holds a branch that compares registers in D
- branchTaken_D  in  1  branch/jump in D resolved taken
- mdUse_D  in  1  D holds mfhi/mflo/mthi/mtlo
- writeReg_E  in  5, regWrite_E  in  1, memRead_E  in  1  destination info of the E instruction
- mdStart_E  in  1  E holds mult/multu/div/divu
- mdDiv_E  in  1  qualifies mdStart_E: 1 = divide
- writeReg_M  in  5, memRead_M  in  1  load in M
- memReq_M  in  1  M issues a data-memory access
- memReady_M  in  1  memory completes the access this cycle
- stall_F, stall_D, stall_E, stall_M  out  1  hold the PC / pipeline register feeding that stage
- flush_D, flush_E, flush_M, flush_WB  out  1  load a bubble into that stage's register
- mdBusy  out  1  mult/div unit occupied
- memErr  out  1  sticky memory-timeout flag
- stallCount  out  16  saturating count of cycles with stall_F = 1

## Operation
- match(r) = (r != 0) & ((useRs_D & instrRs_D == r) | (useRt_D & instrRt_D == r)).
- freeze = memReq_M & ~memReady_M.
- mdHaz = mdStart_E & mdBusy.
- useHaz is true on any of these conditions:
  - (memRead_E & regWrite_E & match(writeReg_E))
  - (branch_D & regWrite_E & match(writeReg_E))
  - (branch_D & memRead_M & match(writeReg_M))
  - (mdUse_D & (mdBusy | mdStart_E))
- Priority, highest first:
  1. freeze: stall_F/D/E/M = 1, flush_WB = 1, all other flushes 0.
  2. mdHaz: stall_F/D/E = 1, flush_M = 1.
  3. useHaz: stall_F/D = 1, flush_E = 1.
  4. otherwise no stalls.
- flush_D = branchTaken_D & ~stall_D. It applies only in cases 3 and 4; in case 2 it is also 0 because stall_D = 1.
- Mult/div counter mdCnt (6 bit):
  - On accept (mdStart_E & ~mdBusy & ~freeze), load MUL_LAT, or DIV_LAT when mdDiv_E = 1.
  - Otherwise decrement while nonzero. Decrement continues during freeze.
  - mdBusy = (mdCnt != 0), registered.
- FSM states are RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when freeze.
  - MEM_WAIT -> RUN in the cycle memReady_M = 1, or when memReq_M drops.
  - waitCnt (8 bit, saturating) clears in RUN and increments each MEM_WAIT cycle.
  - memErr sets when waitCnt reaches MEM_TIMEOUT and stays set until reset. Freeze itself is unaffected.
- stallCount increments each cycle stall_F = 1 and saturates at 16'hFFFF.

## Timing
- Stall/flush outputs are combinational from current inputs and registered state, so they are valid in the same cycle as the hazard.
- mdBusy rises the cycle after accept and stays high for exactly LAT cycles.
- A mdUse_D hazard releases in the first cycle mdBusy = 0.
- Load-use costs exactly 1 stall cycle: next cycle the load is in M and forwarding takes over. branch_D against a load costs 2.
- Reset while rst_n = 0:
  - state = RUN; mdCnt, waitCnt, memErr, stallCount = 0; mdBusy = 0.
  - All stall outputs 0; flush_D/E/M/WB = 1.
- Reset mid-multiply or mid-wait aborts it. The first cycle after release behaves as idle.
- Simultaneous freeze and mdStart_E: no accept. The start is retried on the first unfrozen cycle.
- writeReg = 0 never causes a hazard.

## Test plan
- Load-use: memRead_E = regWrite_E = 1, writeReg_E = 9, instrRs_D = 9, useRs_D = 1 -> stall_F/D = 1 and flush_E = 1 for one cycle; stallCount = 1.
- Branch-on-load: branch_D = 1, instrRt_D = 11, load writeReg_E = 11, then in M -> 2 stall cycles. Rerun with writeReg = 0 -> no stall.
- Divide then mfhi: mdStart_E = mdDiv_E = 1 for one cycle, mdUse_D held high -> mdBusy high 12 cycles. D stalls 13 cycles in total (the start cycle plus 12) and releases when mdBusy falls.
- Back-to-back mult: second mdStart_E while busy -> stall_F/D/E = 1 and flush_M = 1 until mdBusy drops; the second mult is accepted next cycle with LAT = 4.
- Memory wait: memReq_M = 1, memReady_M = 0 for 3 cycles, then 1 -> all stalls plus flush_WB for 3 cycles, state returns to RUN, memErr = 0. Holding memReady_M = 0 for 64 cycles -> memErr = 1.
- Priority/reset: freeze + useHaz + branchTaken_D together -> freeze pattern only, flush_D = 0. rst_n pulsed low mid-divide -> mdBusy = 0, flushes = 1, stallCount = 0.
